// File: rtl/phys_pkg.sv
// Shared types and default constants for the player physics engine.
package phys_pkg;

    typedef enum logic [3:0] {
        IDLE,
        X_A,
        X_B,
        X_EVAL,
        Y_A,
        Y_B,
        Y_EVAL,
        G_A,
        G_B,
        G_EVAL,
        DONE
    } phys_state_t;

    typedef enum logic [1:0] {
        AX_X,
        AX_Y,
        AX_G
    } axis_t;

    localparam int COORD_W = 12;
    typedef logic signed [COORD_W-1:0] coord_t;

    localparam int DEF_POS_W      = 10;
    localparam int DEF_TILE_SHIFT = 5;
    localparam int DEF_MAP_ROWS   = 15;
    localparam int DEF_MAP_COLS   = 20;
    localparam int DEF_OBJ_W      = 26;
    localparam int DEF_OBJ_H      = 32;
    localparam int DEF_RUN_SPEED  = 2;
    localparam int DEF_JUMP_VEL   = 10;
    localparam int DEF_GRAVITY    = 1;
    localparam int DEF_V_TERMINAL = 6;
    localparam int DEF_X_INIT     = 30;
    localparam int DEF_Y_INIT     = 300;

endpackage

// File: rtl/tile_probe.sv
// Two-corner tile lookup for one candidate displacement.
// Corners outside the map read as solid and are never requested.
module tile_probe
    import phys_pkg::*;
#(
    parameter int CW         = COORD_W,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_ROWS   = DEF_MAP_ROWS,
    parameter int MAP_COLS   = DEF_MAP_COLS,
    parameter int OBJ_W      = DEF_OBJ_W,
    parameter int OBJ_H      = DEF_OBJ_H
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         probe_a,
    input  logic                         probe_b,
    input  logic                         probe_eval,
    input  axis_t                        axis,
    input  logic signed [CW-1:0]         x,
    input  logic signed [CW-1:0]         y,
    input  logic signed [CW-1:0]         d,
    output logic                         tile_rd_en,
    output logic [$clog2(MAP_ROWS)-1:0]  tile_row,
    output logic [$clog2(MAP_COLS)-1:0]  tile_col,
    input  logic                         tile_solid,
    output logic                         hit,
    output logic                         hit_valid
);

    localparam int RW  = $clog2(MAP_ROWS);
    localparam int CLW = $clog2(MAP_COLS);

    localparam logic signed [CW-1:0] W1     = CW'(OBJ_W - 1);
    localparam logic signed [CW-1:0] H1     = CW'(OBJ_H - 1);
    localparam logic signed [CW-1:0] ROWS_C = CW'(MAP_ROWS);
    localparam logic signed [CW-1:0] COLS_C = CW'(MAP_COLS);

    logic signed [CW-1:0] lead_x;
    logic signed [CW-1:0] lead_y;
    logic signed [CW-1:0] row_a;
    logic signed [CW-1:0] row_b;
    logic signed [CW-1:0] col_a;
    logic signed [CW-1:0] col_b;
    logic signed [CW-1:0] tr;
    logic signed [CW-1:0] tc;
    logic                 d_pos;
    logic                 oob;
    logic                 oob_d;
    logic                 oob_q;
    logic                 hit_a_d;
    logic                 hit_a_q;

    always_comb begin
        d_pos  = !d[CW-1] && (d != '0);
        lead_x = d_pos ? x + W1 + d : x + d;
        lead_y = d_pos ? y + H1 + d : y + d;
        row_a  = lead_y;
        row_b  = lead_y;
        col_a  = x;
        col_b  = x + W1;
        if (axis == AX_X) begin
            row_a = y;
            row_b = y + H1;
            col_a = lead_x;
            col_b = lead_x;
        end
        tr = (probe_b ? row_b : row_a) >>> TILE_SHIFT;
        tc = (probe_b ? col_b : col_a) >>> TILE_SHIFT;
        oob = tr[CW-1] || tc[CW-1] || (tr >= ROWS_C) || (tc >= COLS_C);
        tile_rd_en = (probe_a || probe_b) && !oob;
        tile_row   = tr[RW-1:0];
        tile_col   = tc[CLW-1:0];
        // oob_q follows the corner whose RAM answer arrives next cycle
        oob_d = oob_q;
        if (probe_a || probe_b) begin
            oob_d = oob;
        end
        hit_a_d = hit_a_q;
        if (probe_b) begin
            hit_a_d = oob_q || tile_solid;
        end
        hit       = hit_a_q || oob_q || tile_solid;
        hit_valid = probe_eval;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            oob_q   <= 1'b0;
            hit_a_q <= 1'b0;
        end else begin
            oob_q   <= oob_d;
            hit_a_q <= hit_a_d;
        end
    end

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion and tile collision; X then Y then ground probe.
// Define PHYS_VAR_JUMP_EN for variable jump height (short hop on release).
module player_physics
    import phys_pkg::*;
#(
    parameter int POS_W      = DEF_POS_W,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_ROWS   = DEF_MAP_ROWS,
    parameter int MAP_COLS   = DEF_MAP_COLS,
    parameter int OBJ_W      = DEF_OBJ_W,
    parameter int OBJ_H      = DEF_OBJ_H,
    parameter int RUN_SPEED  = DEF_RUN_SPEED,
    parameter int JUMP_VEL   = DEF_JUMP_VEL,
    parameter int GRAVITY    = DEF_GRAVITY,
    parameter int V_TERMINAL = DEF_V_TERMINAL,
    parameter int X_INIT     = DEF_X_INIT,
    parameter int Y_INIT     = DEF_Y_INIT
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_tick,
    input  logic                         move_left,
    input  logic                         move_right,
    input  logic                         jump,
    output logic                         tile_rd_en,
    output logic [$clog2(MAP_ROWS)-1:0]  tile_row,
    output logic [$clog2(MAP_COLS)-1:0]  tile_col,
    input  logic                         tile_solid,
    output logic [POS_W-1:0]             pos_x,
    output logic [POS_W-1:0]             pos_y,
    output logic signed [7:0]            vel_y,
    output logic                         on_ground,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int CW = POS_W + 2;

    localparam logic signed [CW-1:0] RUN_C = CW'(RUN_SPEED);
    localparam logic signed [CW-1:0] ONE_C = CW'(1);
    localparam logic signed [CW-1:0] X0    = CW'(X_INIT);
    localparam logic signed [CW-1:0] Y0    = CW'(Y_INIT);
    localparam logic signed [7:0]    JUMP_C  = 8'(JUMP_VEL);
    localparam logic signed [7:0]    GRAV_C  = 8'(GRAVITY);
    localparam logic signed [7:0]    VTERM_C = 8'(V_TERMINAL);
`ifdef PHYS_VAR_JUMP_EN
    localparam logic signed [7:0]    HOP_C   = 8'(JUMP_VEL / 2);
`endif

    phys_state_t state_q, state_d;
    logic signed [CW-1:0] x_q, x_d;
    logic signed [CW-1:0] y_q, y_d;
    logic signed [CW-1:0] d_q, d_d;
    logic signed [CW-1:0] dy_q, dy_d;
    logic signed [7:0]    vel_q, vel_d;
    logic                 on_ground_q, on_ground_d;
    logic [POS_W-1:0]     pos_x_q, pos_x_d;
    logic [POS_W-1:0]     pos_y_q, pos_y_d;
    logic                 overrun_q, overrun_d;

    logic signed [7:0]    v_base;
    logic signed [7:0]    v_fall;
    logic signed [7:0]    v_start;
    logic signed [CW-1:0] dx;
    logic signed [CW-1:0] dy_start;
    logic signed [CW-1:0] d_step;
    logic signed [CW-1:0] probe_d;
    logic                 d_last;
    logic                 probe_a;
    logic                 probe_b;
    logic                 probe_eval;
    logic                 probe_hit;
    logic                 probe_done;
    logic                 coll;
    axis_t                axis;

    always_comb begin
        probe_a    = (state_q == X_A) || (state_q == Y_A) || (state_q == G_A);
        probe_b    = (state_q == X_B) || (state_q == Y_B) || (state_q == G_B);
        probe_eval = (state_q == X_EVAL) || (state_q == Y_EVAL)
                  || (state_q == G_EVAL);
        axis = AX_X;
        if ((state_q == Y_A) || (state_q == Y_B) || (state_q == Y_EVAL)) begin
            axis = AX_Y;
        end
        if ((state_q == G_A) || (state_q == G_B) || (state_q == G_EVAL)) begin
            axis = AX_G;
        end
        probe_d = (axis == AX_G) ? ONE_C : d_q;
    end

    tile_probe #(
        .CW         (CW),
        .TILE_SHIFT (TILE_SHIFT),
        .MAP_ROWS   (MAP_ROWS),
        .MAP_COLS   (MAP_COLS),
        .OBJ_W      (OBJ_W),
        .OBJ_H      (OBJ_H)
    ) u_probe (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .probe_a    (probe_a),
        .probe_b    (probe_b),
        .probe_eval (probe_eval),
        .axis       (axis),
        .x          (x_q),
        .y          (y_q),
        .d          (probe_d),
        .tile_rd_en (tile_rd_en),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .tile_solid (tile_solid),
        .hit        (probe_hit),
        .hit_valid  (probe_done)
    );

    always_comb begin
        v_base = vel_q;
`ifdef PHYS_VAR_JUMP_EN
        if (!jump && (v_base < -HOP_C)) begin
            v_base = -HOP_C;
        end
`endif
        v_fall = v_base + GRAV_C;
        if (v_fall > VTERM_C) begin
            v_fall = VTERM_C;
        end
        v_start  = (jump && on_ground_q) ? -JUMP_C : v_fall;
        dy_start = {{(CW-8){v_start[7]}}, v_start};
        dx = '0;
        if (move_right && !move_left) begin
            dx = RUN_C;
        end else if (move_left && !move_right) begin
            dx = -RUN_C;
        end
        d_step = d_q[CW-1] ? d_q + ONE_C : d_q - ONE_C;
        d_last = (d_q == ONE_C) || (d_q == -ONE_C);
        coll   = probe_hit && probe_done;
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        d_d         = d_q;
        dy_d        = dy_q;
        vel_d       = vel_q;
        on_ground_d = on_ground_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (frame_tick) begin
                    vel_d = v_start;
                    dy_d  = dy_start;
                    if (dx != '0) begin
                        d_d     = dx;
                        state_d = X_A;
                    end else if (dy_start != '0) begin
                        d_d     = dy_start;
                        state_d = Y_A;
                    end else begin
                        state_d = G_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            X_A: state_d = X_B;
            X_B: state_d = X_EVAL;
            X_EVAL: begin
                if (coll && !d_last) begin
                    d_d     = d_step;
                    state_d = X_A;
                end else begin
                    if (!coll) begin
                        x_d = x_q + d_q;
                    end
                    if (dy_q != '0) begin
                        d_d     = dy_q;
                        state_d = Y_A;
                    end else begin
                        state_d = G_A;
                    end
                end
            end
            Y_A: state_d = Y_B;
            Y_B: state_d = Y_EVAL;
            Y_EVAL: begin
                if (coll) begin
                    vel_d = '0;
                end
                if (coll && !d_last) begin
                    d_d     = d_step;
                    state_d = Y_A;
                end else begin
                    if (!coll) begin
                        y_d = y_q + d_q;
                    end
                    state_d = G_A;
                end
            end
            G_A: state_d = G_B;
            G_B: state_d = G_EVAL;
            G_EVAL: begin
                on_ground_d = coll;
                if (coll && !vel_q[7] && (vel_q != '0)) begin
                    vel_d = '0;
                end
                pos_x_d = x_q[POS_W-1:0];
                pos_y_d = y_q[POS_W-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        busy       = (state_q != IDLE) && (state_q != DONE);
        overrun_d  = frame_tick && busy;
        frame_done = (state_q == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            x_q         <= X0;
            y_q         <= Y0;
            d_q         <= '0;
            dy_q        <= '0;
            vel_q       <= '0;
            on_ground_q <= 1'b0;
            pos_x_q     <= X0[POS_W-1:0];
            pos_y_q     <= Y0[POS_W-1:0];
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            d_q         <= d_d;
            dy_q        <= dy_d;
            vel_q       <= vel_d;
            on_ground_q <= on_ground_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign vel_y     = vel_q;
    assign on_ground = on_ground_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics against a small tile map with 1-cycle RAM.
// Floor at rows >= 11, ledge at row 10 cols 16-19 and row 9 cols 17-18.
module tb_player_physics;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              move_left = 1'b0;
    logic              move_right = 1'b0;
    logic              jump = 1'b0;
    logic              tile_rd_en;
    logic [3:0]        tile_row;
    logic [4:0]        tile_col;
    logic              tile_solid = 1'b0;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic signed [7:0] vel_y;
    logic              on_ground;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int ov_cnt = 0;
    int bad_cnt = 0;

    player_physics dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .tile_rd_en (tile_rd_en),
        .tile_row   (tile_row),
        .tile_col   (tile_col),
        .tile_solid (tile_solid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vel_y      (vel_y),
        .on_ground  (on_ground),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic solid(input int r, input int c);
        return (r >= 11) || (r == 10 && c >= 16) || (r == 9 && (c == 17 || c == 18));
    endfunction

    always @(posedge Clk) begin
        if (tile_rd_en) tile_solid <= solid(int'(tile_row), int'(tile_col));
    end

    always @(posedge Clk) begin
        if (tile_rd_en) rd_cnt <= rd_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (tile_rd_en && (tile_row >= 4'd15 || tile_col >= 5'd20)) bad_cnt <= bad_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge that shows frame_done.
    task automatic do_frame(input logic l, input logic r, input logic j, output int lat);
        move_left = l;
        move_right = r;
        jump = j;
        frame_tick = 1'b1;
        lat = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            frame_tick = 1'b0;
            lat++;
            if (frame_done) break;
        end
        if (!frame_done) chk("frame_timeout", 0, 1);
    endtask

    int lat;
    int rd0;
    int fd0;
    int ov0;
    int exp1[6] = '{301, 303, 306, 310, 315, 320};

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_x", pos_x, 30);
        chk("rst_y", pos_y, 300);
        chk("rst_vel", vel_y, 0);
        chk("rst_gnd", on_ground, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_rd", tile_rd_en, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 6; i++) begin
            do_frame(1'b0, 1'b0, 1'b0, lat);
            chk($sformatf("fall_y%0d", i), pos_y, exp1[i]);
        end
        chk("land_vel", vel_y, 0);
        chk("land_gnd", on_ground, 1);

        do_frame(1'b0, 1'b0, 1'b1, lat);
        chk("jump_vel", vel_y, -10);
        chk("jump_y", pos_y, 310);
        chk("jump_gnd", on_ground, 0);
        do_frame(1'b0, 1'b0, 1'b0, lat);
`ifdef PHYS_VAR_JUMP_EN
        chk("jump2_vel", vel_y, -4);
        chk("jump2_y", pos_y, 306);
`else
        chk("jump2_vel", vel_y, -9);
        chk("jump2_y", pos_y, 301);
`endif
        chk("jump2_gnd", on_ground, 0);
        for (int i = 0; i < 60 && !on_ground; i++) do_frame(1'b0, 1'b0, 1'b0, lat);
        chk("reland_y", pos_y, 320);
        chk("reland_vel", vel_y, 0);
        chk("reland_gnd", on_ground, 1);

        for (int i = 0; i < 14; i++) do_frame(1'b1, 1'b0, 1'b0, lat);
        chk("left_x2", pos_x, 2);
        rd0 = rd_cnt;
        do_frame(1'b1, 1'b0, 1'b0, lat);
        chk("left_x0", pos_x, 0);
        chk("left_rd6", rd_cnt - rd0, 6);
        rd0 = rd_cnt;
        do_frame(1'b1, 1'b0, 1'b0, lat);
        chk("edge_x0", pos_x, 0);
        chk("edge_rd4", rd_cnt - rd0, 4);
        chk("edge_lat", lat, 13);

        for (int i = 0; i < 300 && pos_x != 10'd484; i++) do_frame(1'b0, 1'b1, 1'b0, lat);
        chk("walk_x", pos_x, 484);
        do_frame(1'b0, 1'b1, 1'b0, lat);
        chk("wall1_done", frame_done, 1);
        chk("wall1_x", pos_x, 486);
        do_frame(1'b0, 1'b1, 1'b0, lat);
        chk("wall2_done", frame_done, 1);
        chk("wall2_x", pos_x, 486);
        chk("wall2_lat", lat, 13);

        move_right = 1'b0;
        @(negedge Clk);
        fd0 = fd_cnt;
        ov0 = ov_cnt;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (30) @(negedge Clk);
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_frames", fd_cnt - fd0, 1);

        move_left = 1'b1;
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        chk("mid_busy", busy, 1);
        Reset_n = 1'b0;
        #1;
        chk("mid_x", pos_x, 30);
        chk("mid_y", pos_y, 300);
        chk("mid_vel", vel_y, 0);
        chk("mid_gnd", on_ground, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_done", frame_done, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_rd", tile_rd_en, 0);
        move_left = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        do_frame(1'b0, 1'b0, 1'b0, lat);
        chk("post_y", pos_y, 301);
        chk("post_x", pos_x, 30);
        chk("oob_reads", bad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
